// File: rtl/clk_pkg.sv
// clk_pkg: shared state encodings, default timing constants and timer sizing for the PLL sequencer.
package clk_pkg;
    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_state_t;
    localparam int RST_CYCLES_D   = 48;
    localparam int LOCK_STABLE_D  = 4800;
    localparam int LOCK_TIMEOUT_D = 480000;
    localparam int HOLD_CYCLES_D  = 256;
    localparam int LOSS_FILTER_D  = 3;
    localparam int CNT_W_D        = 8;
    function automatic int timer_w(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/sync2.sv
// sync2: generic two-flop synchronizer with synchronous clear to zero.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset/lock sequencer with lock supervision and saturating event counters.
module pll_rst_seq
    import clk_pkg::*;
#(
    parameter int RST_CYCLES   = RST_CYCLES_D,
    parameter int LOCK_STABLE  = LOCK_STABLE_D,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_D,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_D,
    parameter int LOSS_FILTER  = LOSS_FILTER_D,
    parameter int CNT_W        = CNT_W_D
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             locked,
    input  logic             relock_req,
    input  logic             clr_stat,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] relock_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic             lost
);
    localparam int TW = timer_w(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT, HOLD_CYCLES, LOSS_FILTER);
    pll_state_t st, nxt;
    logic [TW-1:0] timer, streak;
    logic lock_s, loss, tmo;
    sync2 #(.W(1)) u_sync (.clk(clkin), .rst(rst), .d(locked), .q(lock_s));
    always_comb begin
        nxt  = st;
        loss = 1'b0;
        tmo  = 1'b0;
        case (st)
            RESET_PLL: nxt = (timer == TW'(RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK:
                if (relock_req) nxt = RESET_PLL;
                else if (lock_s && streak == TW'(LOCK_STABLE - 1)) nxt = HOLD;
                else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                    nxt = RESET_PLL;
                    tmo = 1'b1;
                end
            HOLD:
                if (relock_req) nxt = RESET_PLL;
                else if (!lock_s) begin
                    nxt  = RESET_PLL;
                    loss = 1'b1;
                end else if (timer == TW'(HOLD_CYCLES - 1)) nxt = RUN;
            default:
                if (relock_req) nxt = RESET_PLL;
                else if (!lock_s && streak == TW'(LOSS_FILTER - 1)) begin
                    nxt  = RESET_PLL;
                    loss = 1'b1;
                end
        endcase
    end
    always_ff @(posedge clkin) begin
        if (rst) begin
            st          <= RESET_PLL;
            timer       <= '0;
            streak      <= '0;
            relock_cnt  <= '0;
            timeout_cnt <= '0;
            lost        <= 1'b0;
        end else begin
            st     <= nxt;
            timer  <= (nxt != st) ? '0 : timer + 1'b1;
            // streak counts lock highs while waiting, lock lows while running
            streak <= (nxt != st) ? '0 :
                      (st == WAIT_LOCK) ? (lock_s ? streak + 1'b1 : '0) :
                      (st == RUN) ? (lock_s ? '0 : streak + 1'b1) : '0;
            relock_cnt  <= clr_stat ? '0 : (loss && relock_cnt != '1) ? relock_cnt + 1'b1 : relock_cnt;
            timeout_cnt <= clr_stat ? '0 : (tmo && timeout_cnt != '1) ? timeout_cnt + 1'b1 : timeout_cnt;
            lost        <= clr_stat ? 1'b0 : (lost | loss);
        end
    end
    assign pll_rst = (st == RESET_PLL);
    assign sys_rst = (st != RUN);
    assign ready   = (st == RUN);
    assign state   = st;
endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Reset and lock sequencer for the `pll` block, clocked from the free-running 48 MHz board input, not from the PLL output.
- Drives the PLL reset.
- Qualifies the asynchronous `locked` signal and holds the system reset until the synthesized clock is stable.
- Supervises lock during operation and re-sequences the PLL on loss of lock or on software request, keeping saturating event counters.
- Its `sys_rst` output is resynchronized by each consumer in the `clkout0` domain.

## Interface
Parameters:
- `RST_CYCLES`, 48: cycles `pll_rst` is held high per attempt (1 µs at 48 MHz).
- `LOCK_STABLE`, 4800: consecutive synchronized-lock-high cycles required before lock counts as acquired (100 µs).
- `LOCK_TIMEOUT`, 480000: maximum cycles spent waiting for lock before the PLL is reset again (10 ms).
- `HOLD_CYCLES`, 256: cycles `sys_rst` stays high after lock is acquired.
- `LOSS_FILTER`, 3: consecutive synchronized-lock-low cycles in RUN that count as loss of lock.
- `CNT_W`, 8: width of the status counters.

Ports:
- `clkin` in 1: free-running 48 MHz reference clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock, asynchronous to `clkin`.
- `relock_req` in 1: single-cycle pulse that forces a full re-sequence.
- `clr_stat` in 1: single-cycle pulse that clears the counters and `lost`.
- `pll_rst` out 1: PLL reset, active high (iCE40 `RESETB` = ~`pll_rst`).
- `sys_rst` out 1: system reset, active high.
- `ready` out 1: high only in RUN; always equals ~`sys_rst`.
- `state` out 2: current state encoding.
- `relock_cnt` out CNT_W: number of lock losses detected in RUN or HOLD; saturating.
- `timeout_cnt` out CNT_W: number of lock-wait timeouts; saturating.
- `lost` out 1: sticky flag, set on any lock loss.

## Operation
- `locked` passes through a 2-FF synchronizer to produce `lock_s`. Both synchronizer flops reset to 0.
- States: RESET_PLL=0, WAIT_LOCK=1, HOLD=2, RUN=3. Outputs are Moore-decoded from the registered state:
  - `pll_rst` = (state==RESET_PLL)
  - `sys_rst` = (state!=RUN)
- One shared timer, sized `$clog2` of the largest parameter, clears on every state change. A separate streak counter tracks runs of consecutive `lock_s` values.
- RESET_PLL: when timer == RST_CYCLES-1 → WAIT_LOCK. `relock_req` is ignored in this state.
- WAIT_LOCK:
  - Streak counts consecutive `lock_s`=1 cycles and clears to 0 whenever `lock_s`=0.
  - Streak reaches LOCK_STABLE with `lock_s`=1 → HOLD.
  - Else timer == LOCK_TIMEOUT-1 → RESET_PLL, `timeout_cnt`++.
  - Success and timeout in the same cycle: success wins, no timeout count.
- HOLD:
  - `lock_s`=0 in any cycle → RESET_PLL, `relock_cnt`++, `lost`=1.
  - Else timer == HOLD_CYCLES-1 → RUN.
- RUN:
  - Streak counts consecutive `lock_s`=0 cycles.
  - Streak reaches LOSS_FILTER → RESET_PLL, `relock_cnt`++, `lost`=1.
  - Shorter low glitches are ignored, and the streak clears on `lock_s`=1.
- `relock_req` in WAIT_LOCK, HOLD or RUN → RESET_PLL on the next edge; no counter changes. It takes priority over a same-cycle loss or timeout event, which is then dropped.
- Counters saturate at 2^CNT_W-1.
- `clr_stat` clears `relock_cnt`, `timeout_cnt` and `lost`. If it coincides with an increment or set, the clear wins.

## Timing
- Reset values: state=RESET_PLL, `pll_rst`=1, `sys_rst`=1, `ready`=0, `state`=0, counters=0, `lost`=0, timer=0, streak=0.
- `rst` mid-operation: everything returns to reset values on the next edge, with no counter increment.
- The edge on which `rst` is sampled low is edge 0:
  - `pll_rst` is high for exactly RST_CYCLES cycles.
  - With `locked` constantly high, `sys_rst` falls after exactly RST_CYCLES+LOCK_STABLE+HOLD_CYCLES edges. The 2-cycle synchronizer latency is absorbed during RESET_PLL whenever RST_CYCLES ≥ 2.
- Loss detection in RUN: `sys_rst` rises 2+LOSS_FILTER edges after `locked` falls.
- `relock_req`: `pll_rst` and `sys_rst` rise 1 edge after the request is sampled.
- Every output is a flop or a single decode of the state register; there are no combinational paths from input to output.

## Structure
- Shared package `clk_pkg`:
  - state enum encodings
  - default parameter constants
  - `TIMER_W` computation function
- Sub-module `sync2` (generic 2-FF synchronizer, reset value 0), reused for other async inputs in the design.
- Instantiated in the top level next to `pll`. `locked` connects straight in; `pll_rst` connects to the PLL reset where the PLL's reset input is enabled.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, HOLD_CYCLES=4, LOSS_FILTER=3, CNT_W=2.
- `locked`=1 from time 0, then release `rst` → `pll_rst` high for edges 1–4, `sys_rst` falls at edge 16, `ready`=1, counters 0.
- `locked` held 0 → RESET_PLL/WAIT_LOCK cycle repeats every 36 edges; `timeout_cnt` goes 1,2,3 and stays at 3 (saturates).
- In RUN, `locked` low for 2 cycles → no state change. Low for 3 cycles → `sys_rst` rises 5 edges after the fall, `relock_cnt`=1, `lost`=1.
- In WAIT_LOCK, `lock_s` drops after a streak of 7 → streak restarts. A timeout coinciding with the 8th high cycle → HOLD, `timeout_cnt` unchanged.
- `relock_req` in RUN together with a LOSS_FILTER loss → RESET_PLL next edge, `relock_cnt` unchanged. `clr_stat` together with an increment → counters read 0.
- Assert `rst` during HOLD → all outputs return to reset values on the next edge; full sequence restarts.
